pic_init_sequencer: RTL and testbench
=====================================

Name: pic_init_sequencer

Overview:
- Command-sequencing stage directly downstream of the 8259A read/write logic.
- Consumes each latched CPU write (byte + A0) through the write_flag / write_flag_ACK handshake.
- Tracks the ICW1..ICW4 initialisation sequence, classifies post-init writes as OCW1/OCW2/OCW3, and presents decoded configuration and command fields to the control logic, IRR/ISR and priority resolver.

Parameters:
- IMR_RST, 8'h00, IMR value at reset and on every ICW1.
- POLL_PULSE, 1, 1 = poll and ocw2_valid are one-cycle pulses; 0 = held until the next accepted write.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- write_flag  in  1  write request level from the read/write logic, held until acknowledged
- wr_a0  in  1  A0 captured with the write
- wr_data  in  8  data byte captured with the write
- write_flag_ACK  out  1  one-cycle acknowledge
- init_done  out  1  initialisation sequence complete
- seq_state  out  3  current FSM state (debug)
- ltim  out  1  ICW1[3], level-triggered mode
- sngl  out  1  ICW1[1], single mode
- ic4  out  1  ICW1[0], ICW4 needed
- vector_base  out  5  ICW2[7:3]
- cascade_cfg  out  8  ICW3 byte
- upm  out  1  ICW4[0]
- aeoi  out  1  ICW4[1]
- ms  out  1  ICW4[2]
- buf_mode  out  1  ICW4[3]
- sfnm  out  1  ICW4[4]
- imr  out  8  OCW1 mask
- ocw2_valid  out  1  OCW2 accepted
- ocw2_rsleoi  out  3  OCW2[7:5], R/SL/EOI
- ocw2_level  out  3  OCW2[2:0]
- read_ris  out  1  1 = ISR selected, 0 = IRR selected
- poll  out  1  OCW3 poll command
- smm  out  1  special mask mode

Behaviour:
- Reset (asynchronous, active-high):
  - State IDLE.
  - All outputs 0, except imr = IMR_RST.
  - busy cleared.
- Handshake:
  - A write is accepted on the rising clk edge where write_flag=1 and busy=0.
  - write_flag_ACK=1 in the following cycle only.
  - busy is set at acceptance and clears on the first edge that samples write_flag=0.
  - A write_flag held high therefore produces exactly one acceptance.
- Classification (evaluated at acceptance):
  - ICW1: A0=0 and D4=1, in any state. Captures ltim/sngl/ic4, clears the ICW4 fields (upm, aeoi, ms, buf_mode, sfnm), cascade_cfg, smm and read_ris. Sets imr=IMR_RST and init_done=0, then goes to WAIT_ICW2.
  - WAIT_ICW2:
    - A0=1 captures vector_base.
    - Next state WAIT_ICW3 if sngl=0; else WAIT_ICW4 if ic4=1; else READY.
  - WAIT_ICW3:
    - A0=1 captures cascade_cfg.
    - Next state WAIT_ICW4 if ic4=1, else READY.
  - WAIT_ICW4:
    - A0=1 captures bits [4:0].
    - Next state READY.
  - In any WAIT state, A0=0 with D4=0 is acknowledged and ignored; the state is unchanged.
  - IDLE: every non-ICW1 write is acknowledged and ignored.
  - READY:
    - A0=1 is OCW1: imr=wr_data.
    - A0=0, D4=0, D3=0 is OCW2: latches ocw2_rsleoi and ocw2_level, and pulses ocw2_valid.
    - A0=0, D4=0, D3=1 is OCW3:
      - D1=1 updates read_ris to D0; D1=0 leaves it unchanged.
      - D6=1 updates smm to D5; D6=0 leaves it unchanged.
      - D2=1 asserts poll.
- Timing:
  - All captured registers, init_done and the pulses update in the same cycle write_flag_ACK is high, i.e. one cycle after acceptance.
  - init_done=1 from the cycle the state enters READY.
- ICW1 mid-sequence (including from WAIT_ICW3/WAIT_ICW4): restarts the sequence; the partially captured fields are overwritten or cleared as above.
- Reset mid-handshake: write_flag_ACK drops immediately; a still-high write_flag is accepted as a new write after reset deasserts.
- seq_state encoding: IDLE=0, WAIT_ICW2=1, WAIT_ICW3=2, WAIT_ICW4=3, READY=4.

Decomposition:
- Shared package pic_pkg:
  - state encoding constants;
  - bit-position constants (ICW1_IC4=0, ICW1_SNGL=1, ICW1_LTIM=3, ICW1_ID=4, OCW3_ID=3, OCW3_P=2, OCW3_RR=1, OCW3_RIS=0, OCW3_ESMM=6, OCW3_SMM=5);
  - OCW2 command codes (non-specific EOI=3'b001, specific EOI=3'b011, rotate on non-specific EOI=3'b101).
- One natural sub-module: pic_wr_handshake, containing the accept / busy / ACK logic, producing a single-cycle accept strobe.

Test Plan:
- Reset, then 8'h13 A0=0 (single, IC4) -> WAIT_ICW2; 8'h20 A0=1 -> vector_base=5'h04, WAIT_ICW4; 8'h03 A0=1 -> upm=1, aeoi=1, init_done=1, state READY.
- Cascade: 8'h11, then 8'h40, then 8'h04, then 8'h01 -> passes through WAIT_ICW3; cascade_cfg=8'h04, init_done=1 after the fourth ACK.
- In READY: OCW1 8'hA5 -> imr=8'hA5; OCW2 8'h63 -> ocw2_valid pulses 1 cycle with rsleoi=3'b011, level=3; OCW3 8'h0B -> read_ris=1; OCW3 8'h0C -> poll pulse, read_ris still 1.
- write_flag held high for 10 cycles -> exactly one ACK and one capture; drop for 1 cycle and re-raise -> second acceptance.
- ICW1 8'h12 issued in WAIT_ICW3 -> imr=8'h00, cascade_cfg=0, state WAIT_ICW2, init_done=0.
- Reset asserted during WAIT_ICW4 with write_flag high -> all outputs cleared asynchronously; after release, the pending write is treated as an IDLE write and ignored unless it is an ICW1.

Source files
------------

// File: rtl/pic_init_sequencer_pkg.sv
// Shared encodings for the 8259A init sequencer: FSM states, ICW/OCW bit positions, OCW2 codes.
// Pure declarations; no timing or flow control of its own.
package pic_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_ICW2 = 3'd1,
      ST_WAIT_ICW3 = 3'd2,
      ST_WAIT_ICW4 = 3'd3,
      ST_READY     = 3'd4
   } seq_state_e;

   localparam int ICW1_IC4  = 0;
   localparam int ICW1_SNGL = 1;
   localparam int ICW1_LTIM = 3;
   localparam int ICW1_ID   = 4;

   localparam int OCW3_ID   = 3;
   localparam int OCW3_P    = 2;
   localparam int OCW3_RR   = 1;
   localparam int OCW3_RIS  = 0;
   localparam int OCW3_ESMM = 6;
   localparam int OCW3_SMM  = 5;

   localparam logic [2:0] OCW2_NS_EOI     = 3'b001;
   localparam logic [2:0] OCW2_SP_EOI     = 3'b011;
   localparam logic [2:0] OCW2_ROT_NS_EOI = 3'b101;

   // ICW3 is only expected in cascade mode; ICW4 only when ICW1 asked for it.
   function automatic seq_state_e after_icw2(input logic sngl, input logic ic4);
      if (!sngl) begin
         return ST_WAIT_ICW3;
      end else if (ic4) begin
         return ST_WAIT_ICW4;
      end else begin
         return ST_READY;
      end
   endfunction

   function automatic seq_state_e after_icw3(input logic ic4);
      return ic4 ? ST_WAIT_ICW4 : ST_READY;
   endfunction

endpackage

// File: rtl/pic_init_sequencer_if.sv
// Latched CPU write from the read/write logic: level request plus byte/A0, one-cycle acknowledge back.
// The master holds write_flag until it sees write_flag_ACK.
interface pic_init_sequencer_if;
   logic       write_flag;
   logic       wr_a0;
   logic [7:0] wr_data;
   logic       write_flag_ACK;

   modport master (output write_flag, output wr_a0, output wr_data, input write_flag_ACK);
   modport slave  (input write_flag, input wr_a0, input wr_data, output write_flag_ACK);
endinterface

// File: rtl/pic_init_sequencer_wr_handshake.sv
// Turns the level write_flag into a single accept strobe; ACK follows one cycle later.
// A request held high is accepted once; write_flag must be seen low before the next acceptance.
module pic_wr_handshake (
   input  logic clk,
   input  logic reset,
   input  logic write_flag,
   output logic accept,
   output logic ack
);

   logic busy_q, busy_d;
   logic ack_q, ack_d;

   always_comb begin
      accept = write_flag & ~busy_q;
      busy_d = busy_q;
      if (accept) begin
         busy_d = 1'b1;
      end else if (!write_flag) begin
         busy_d = 1'b0;
      end
      ack_d = accept;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_q <= 1'b0;
         ack_q  <= 1'b0;
      end else begin
         busy_q <= busy_d;
         ack_q  <= ack_d;
      end
   end

   assign ack = ack_q;

endmodule

// File: rtl/pic_init_sequencer.sv
// 8259A command sequencer: walks ICW1..ICW4, then decodes OCW1/2/3 into config and command fields.
// Fields update in the ACK cycle (one cycle after acceptance); one write in flight, held requests accepted once.
module pic_init_sequencer
   import pic_pkg::*;
#(
   parameter logic [7:0] IMR_RST    = 8'h00,
   parameter bit         POLL_PULSE = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset,
   pic_init_sequencer_if.slave    wr,
   output logic                   init_done,
   output logic [2:0]             seq_state,
   output logic                   ltim,
   output logic                   sngl,
   output logic                   ic4,
   output logic [4:0]             vector_base,
   output logic [7:0]             cascade_cfg,
   output logic                   upm,
   output logic                   aeoi,
   output logic                   ms,
   output logic                   buf_mode,
   output logic                   sfnm,
   output logic [7:0]             imr,
   output logic                   ocw2_valid,
   output logic [2:0]             ocw2_rsleoi,
   output logic [2:0]             ocw2_level,
   output logic                   read_ris,
   output logic                   poll,
   output logic                   smm
);

   logic accept;
   logic ack;

   pic_wr_handshake u_hs (
      .clk        (clk),
      .reset      (reset),
      .write_flag (wr.write_flag),
      .accept     (accept),
      .ack        (ack)
   );

   assign wr.write_flag_ACK = ack;

   seq_state_e state_q, state_d;
   logic       init_done_q, init_done_d;
   logic       ltim_q, ltim_d;
   logic       sngl_q, sngl_d;
   logic       ic4_q, ic4_d;
   logic [4:0] vb_q, vb_d;
   logic [7:0] cas_q, cas_d;
   logic [4:0] icw4_q, icw4_d;
   logic [7:0] imr_q, imr_d;
   logic       ocw2_valid_q, ocw2_valid_d;
   logic [2:0] rsleoi_q, rsleoi_d;
   logic [2:0] level_q, level_d;
   logic       ris_q, ris_d;
   logic       poll_q, poll_d;
   logic       smm_q, smm_d;

   logic       a0;
   logic [7:0] d;

   assign a0 = wr.wr_a0;
   assign d  = wr.wr_data;

   always_comb begin
      state_d      = state_q;
      ltim_d       = ltim_q;
      sngl_d       = sngl_q;
      ic4_d        = ic4_q;
      vb_d         = vb_q;
      cas_d        = cas_q;
      icw4_d       = icw4_q;
      imr_d        = imr_q;
      ocw2_valid_d = ocw2_valid_q;
      rsleoi_d     = rsleoi_q;
      level_d      = level_q;
      ris_d        = ris_q;
      poll_d       = poll_q;
      smm_d        = smm_q;

      if (POLL_PULSE) begin
         ocw2_valid_d = 1'b0;
         poll_d       = 1'b0;
      end

      if (accept) begin
         ocw2_valid_d = 1'b0;
         poll_d       = 1'b0;
         // ICW1 is recognised in every state and always restarts the sequence.
         if (!a0 && d[ICW1_ID]) begin
            ltim_d  = d[ICW1_LTIM];
            sngl_d  = d[ICW1_SNGL];
            ic4_d   = d[ICW1_IC4];
            icw4_d  = 5'd0;
            cas_d   = 8'd0;
            smm_d   = 1'b0;
            ris_d   = 1'b0;
            imr_d   = IMR_RST;
            state_d = ST_WAIT_ICW2;
         end else begin
            case (state_q)
               ST_WAIT_ICW2: if (a0) begin
                  vb_d    = d[7:3];
                  state_d = after_icw2(sngl_q, ic4_q);
               end
               ST_WAIT_ICW3: if (a0) begin
                  cas_d   = d;
                  state_d = after_icw3(ic4_q);
               end
               ST_WAIT_ICW4: if (a0) begin
                  icw4_d  = d[4:0];
                  state_d = ST_READY;
               end
               ST_READY: begin
                  if (a0) begin
                     imr_d = d;
                  end else if (!d[OCW3_ID]) begin
                     rsleoi_d     = d[7:5];
                     level_d      = d[2:0];
                     ocw2_valid_d = 1'b1;
                  end else begin
                     if (d[OCW3_RR]) begin
                        ris_d = d[OCW3_RIS];
                     end
                     if (d[OCW3_ESMM]) begin
                        smm_d = d[OCW3_SMM];
                     end
                     if (d[OCW3_P]) begin
                        poll_d = 1'b1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end

      init_done_d = (state_d == ST_READY);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         init_done_q  <= 1'b0;
         ltim_q       <= 1'b0;
         sngl_q       <= 1'b0;
         ic4_q        <= 1'b0;
         vb_q         <= 5'd0;
         cas_q        <= 8'd0;
         icw4_q       <= 5'd0;
         imr_q        <= IMR_RST;
         ocw2_valid_q <= 1'b0;
         rsleoi_q     <= 3'd0;
         level_q      <= 3'd0;
         ris_q        <= 1'b0;
         poll_q       <= 1'b0;
         smm_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         init_done_q  <= init_done_d;
         ltim_q       <= ltim_d;
         sngl_q       <= sngl_d;
         ic4_q        <= ic4_d;
         vb_q         <= vb_d;
         cas_q        <= cas_d;
         icw4_q       <= icw4_d;
         imr_q        <= imr_d;
         ocw2_valid_q <= ocw2_valid_d;
         rsleoi_q     <= rsleoi_d;
         level_q      <= level_d;
         ris_q        <= ris_d;
         poll_q       <= poll_d;
         smm_q        <= smm_d;
      end
   end

   assign seq_state   = state_q;
   assign init_done   = init_done_q;
   assign ltim        = ltim_q;
   assign sngl        = sngl_q;
   assign ic4         = ic4_q;
   assign vector_base = vb_q;
   assign cascade_cfg = cas_q;
   assign upm         = icw4_q[0];
   assign aeoi        = icw4_q[1];
   assign ms          = icw4_q[2];
   assign buf_mode    = icw4_q[3];
   assign sfnm        = icw4_q[4];
   assign imr         = imr_q;
   assign ocw2_valid  = ocw2_valid_q;
   assign ocw2_rsleoi = rsleoi_q;
   assign ocw2_level  = level_q;
   assign read_ris    = ris_q;
   assign poll        = poll_q;
   assign smm         = smm_q;

endmodule

// File: tb/tb_pic_init_sequencer.sv
// Directed test-plan steps followed by random writes, all checked against a queue-based model of the ICW/OCW rules.
module tb_pic_init_sequencer;
   import pic_pkg::*;

   localparam logic [7:0] IMR_RST = 8'h00;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pic_init_sequencer_if wr_if ();

   logic       init_done, ltim, sngl, ic4, upm, aeoi, ms, buf_mode, sfnm;
   logic       ocw2_valid, read_ris, poll, smm;
   logic [2:0] seq_state, ocw2_rsleoi, ocw2_level;
   logic [4:0] vector_base;
   logic [7:0] cascade_cfg, imr;

   pic_init_sequencer #(.IMR_RST(IMR_RST), .POLL_PULSE(1'b1)) dut (
      .clk         (clk),
      .reset       (reset),
      .wr          (wr_if),
      .init_done   (init_done),
      .seq_state   (seq_state),
      .ltim        (ltim),
      .sngl        (sngl),
      .ic4         (ic4),
      .vector_base (vector_base),
      .cascade_cfg (cascade_cfg),
      .upm         (upm),
      .aeoi        (aeoi),
      .ms          (ms),
      .buf_mode    (buf_mode),
      .sfnm        (sfnm),
      .imr         (imr),
      .ocw2_valid  (ocw2_valid),
      .ocw2_rsleoi (ocw2_rsleoi),
      .ocw2_level  (ocw2_level),
      .read_ris    (read_ris),
      .poll        (poll),
      .smm         (smm)
   );

   int compared   = 0;
   int mismatched = 0;

   // Reference model: ICWs still owed are kept as a queue of their numbers.
   bit       m_seen;
   int       m_pend[$];
   bit       m_ack, m_ltim, m_sngl, m_ic4, m_ocw2v, m_poll, m_ris, m_smm, m_init;
   bit [4:0] m_vb, m_icw4;
   bit [7:0] m_cas, m_imr;
   bit [2:0] m_rsleoi, m_level;

   function automatic logic [2:0] m_state();
      if (!m_seen) return 3'd0;
      if (m_pend.size() > 0) return 3'(m_pend[0] - 1);
      return 3'd4;
   endfunction

   task automatic m_reset();
      m_seen = 0; m_pend.delete(); m_ack = 0;
      m_ltim = 0; m_sngl = 0; m_ic4 = 0; m_ocw2v = 0; m_poll = 0; m_ris = 0; m_smm = 0; m_init = 0;
      m_vb = 0; m_icw4 = 0; m_cas = 0; m_imr = IMR_RST; m_rsleoi = 0; m_level = 0;
   endtask

   task automatic m_apply(input bit a0, input bit [7:0] d);
      int n;
      m_ocw2v = 0; m_poll = 0;
      if (!a0 && d[4]) begin
         m_seen = 1;
         m_ltim = d[3]; m_sngl = d[1]; m_ic4 = d[0];
         m_icw4 = 0; m_cas = 0; m_smm = 0; m_ris = 0; m_imr = IMR_RST; m_init = 0;
         m_pend.delete();
         m_pend.push_back(2);
         if (!d[1]) m_pend.push_back(3);
         if (d[0]) m_pend.push_back(4);
      end else if (!m_seen) begin
      end else if (m_pend.size() > 0) begin
         if (a0) begin
            n = m_pend.pop_front();
            if (n == 2) m_vb = d[7:3];
            else if (n == 3) m_cas = d;
            else m_icw4 = d[4:0];
            if (m_pend.size() == 0) m_init = 1;
         end
      end else if (a0) begin
         m_imr = d;
      end else if (!d[3]) begin
         m_rsleoi = d[7:5]; m_level = d[2:0]; m_ocw2v = 1;
      end else begin
         if (d[1]) m_ris = d[0];
         if (d[6]) m_smm = d[5];
         if (d[2]) m_poll = 1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string ctx);
      chk({ctx, "/ack"},       32'(wr_if.write_flag_ACK), 32'(m_ack));
      chk({ctx, "/state"},     32'(seq_state),   32'(m_state()));
      chk({ctx, "/init_done"}, 32'(init_done),   32'(m_init));
      chk({ctx, "/ltim"},      32'(ltim),        32'(m_ltim));
      chk({ctx, "/sngl"},      32'(sngl),        32'(m_sngl));
      chk({ctx, "/ic4"},       32'(ic4),         32'(m_ic4));
      chk({ctx, "/vbase"},     32'(vector_base), 32'(m_vb));
      chk({ctx, "/cascade"},   32'(cascade_cfg), 32'(m_cas));
      chk({ctx, "/icw4"},      32'({sfnm, buf_mode, ms, aeoi, upm}), 32'(m_icw4));
      chk({ctx, "/imr"},       32'(imr),         32'(m_imr));
      chk({ctx, "/ocw2_vld"},  32'(ocw2_valid),  32'(m_ocw2v));
      chk({ctx, "/rsleoi"},    32'(ocw2_rsleoi), 32'(m_rsleoi));
      chk({ctx, "/level"},     32'(ocw2_level),  32'(m_level));
      chk({ctx, "/read_ris"},  32'(read_ris),    32'(m_ris));
      chk({ctx, "/poll"},      32'(poll),        32'(m_poll));
      chk({ctx, "/smm"},       32'(smm),         32'(m_smm));
   endtask

   task automatic release_write(input string ctx);
      @(negedge clk);
      wr_if.write_flag = 1'b0;
      @(posedge clk); #1;
      m_ack = 0; m_ocw2v = 0; m_poll = 0;
      check_all({ctx, ":rel"});
   endtask

   task automatic do_write(input string ctx, input bit a0, input bit [7:0] d, input int hold);
      @(negedge clk);
      wr_if.write_flag = 1'b1; wr_if.wr_a0 = a0; wr_if.wr_data = d;
      @(posedge clk); #1;
      m_apply(a0, d); m_ack = 1;
      check_all({ctx, ":acc"});
      for (int i = 1; i < hold; i++) begin
         @(posedge clk); #1;
         m_ack = 0; m_ocw2v = 0; m_poll = 0;
         check_all({ctx, ":hold"});
      end
      release_write(ctx);
   endtask

   initial begin
      wr_if.write_flag = 1'b0; wr_if.wr_a0 = 1'b0; wr_if.wr_data = 8'h00;
      reset = 1'b1;
      m_reset();
      #1 check_all("reset");
      repeat (2) @(negedge clk);
      reset = 1'b0;

      do_write("idle_ign", 1'b0, 8'h05, 1);
      // Single mode with ICW4.
      do_write("icw1_13", 1'b0, 8'h13, 1);
      chk("icw1_13/state_lit", 32'(seq_state), 32'd1);
      do_write("wait_ign", 1'b0, 8'h0A, 1);
      do_write("icw2_20", 1'b1, 8'h20, 1);
      chk("icw2_20/vb_lit", 32'(vector_base), 32'h04);
      do_write("icw4_03", 1'b1, 8'h03, 1);
      chk("icw4_03/ready_lit", 32'({init_done, seq_state}), 32'h0C);

      // Cascade mode.
      do_write("casc_icw1", 1'b0, 8'h11, 1);
      do_write("casc_icw2", 1'b1, 8'h40, 1);
      chk("casc/wait3_lit", 32'(seq_state), 32'd2);
      do_write("casc_icw3", 1'b1, 8'h04, 1);
      do_write("casc_icw4", 1'b1, 8'h01, 1);
      chk("casc/done_lit", 32'({init_done, cascade_cfg}), 32'h104);

      // Operational commands.
      do_write("ocw1_a5", 1'b1, 8'hA5, 1);
      do_write("ocw2_63", 1'b0, 8'h63, 1);
      do_write("ocw2_ns", 1'b0, {OCW2_NS_EOI, 5'b00000}, 1);
      do_write("ocw2_rot", 1'b0, {OCW2_ROT_NS_EOI, 5'b00110}, 1);
      do_write("ocw3_0b", 1'b0, 8'h0B, 1);
      do_write("ocw3_0c", 1'b0, 8'h0C, 1);
      do_write("ocw3_smm", 1'b0, 8'h68, 1);

      // Held request then a one-cycle gap.
      do_write("hold10", 1'b1, 8'h3C, 10);
      do_write("rearm", 1'b1, 8'h5A, 1);

      // ICW1 while waiting for ICW3.
      do_write("rst_icw1", 1'b0, 8'h11, 1);
      do_write("rst_icw2", 1'b1, 8'h48, 1);
      do_write("mid_icw1", 1'b0, 8'h12, 1);
      chk("mid_icw1/lit", 32'({init_done, seq_state, cascade_cfg, imr}), 32'h10000);

      // Reset mid-handshake from WAIT_ICW4.
      do_write("pre_icw1", 1'b0, 8'h13, 1);
      do_write("pre_icw2", 1'b1, 8'h20, 1);
      @(negedge clk);
      wr_if.write_flag = 1'b1; wr_if.wr_a0 = 1'b1; wr_if.wr_data = 8'h05;
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      m_reset();
      check_all("async_rst");
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      m_apply(1'b1, 8'h05); m_ack = 1;
      check_all("post_rst:acc");
      release_write("post_rst");

      for (int n = 0; n < 250; n++) begin
         int       kind;
         bit       a0;
         bit [7:0] d;
         kind = $urandom_range(0, 9);
         d    = 8'($urandom);
         if (kind == 0) begin
            a0 = 1'b0; d[4] = 1'b1;
         end else if (kind <= 6) begin
            a0 = 1'b1;
         end else begin
            a0 = 1'b0; d[4] = 1'b0;
         end
         do_write("rand", a0, d, $urandom_range(1, 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
